seq_divider_2bit: RTL and testbench



---
 rtl/seq_divider_2bit_pkg.sv | 15 +
 rtl/seq_divider_2bit_trial_subtractor.sv | 23 ++
 rtl/seq_divider_2bit.sv | 138 +++++++++++++
 tb/tb_seq_divider_2bit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_2bit_pkg.sv
// Shared definitions for the 2-bit ALU divider: operand width,
// the default divide-by-zero quotient and the controller state encoding.
package alu_div_pkg;

    localparam int OPW = 2;

    localparam logic [OPW-1:0] DZ_QUOT_DEFAULT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_2bit_trial_subtractor.sv
// 3-bit ripple subtractor built from full-subtractor cells, the mirror image
// of the full-adder cell used in the adder path. Computes x - y; borrow is set
// when y > x, which tells the divider the trial value was too small.
module trial_subtractor (
    input  logic [2:0] x,
    input  logic [2:0] y,
    output logic [2:0] diff,
    output logic       borrow
);

    logic [3:0] bw;

    assign bw[0] = 1'b0;

    // One full-subtractor cell per bit, borrow rippling from LSB to MSB
    for (genvar i = 0; i < 3; i++) begin : g_cell
        assign diff[i]  = x[i] ^ y[i] ^ bw[i];
        assign bw[i+1]  = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw[i]);
    end

    assign borrow = bw[3];

endmodule

// File: rtl/seq_divider_2bit.sv
// Sequential 2-bit restoring divider with a start/busy/done handshake.
// One quotient bit is resolved per clock, MSB first; divide-by-zero is
// detected on accept and finishes in a single edge.
module seq_divider_2bit
    import alu_div_pkg::*;
#(
    parameter logic [OPW-1:0] DZ_QUOT     = DZ_QUOT_DEFAULT,
    parameter bit             DZ_REM_PASS = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    output logic busy,
    output logic done,
    output logic dz,
    output logic q0,
    output logic q1,
    output logic r0,
    output logic r1
);

    div_state_t     state, state_next;
    logic [OPW-1:0] a_reg, a_next;
    logic [OPW-1:0] b_reg, b_next;
    logic [2:0]     rem, rem_next;
    logic [OPW-1:0] quot, quot_next;
    logic           cnt, cnt_next;
    logic           dz_reg, dz_next;

    logic [OPW-1:0] a_in, b_in;
    logic [2:0]     trial;
    logic [2:0]     diff;
    logic           borrow;
    logic           rem_msb_unused;

    assign a_in  = {a1, a0};
    assign b_in  = {b1, b0};

    // Shift the next dividend bit into the partial remainder
    assign trial = {rem[1:0], a_reg[cnt]};

    trial_subtractor u_trial_subtractor (
        .x      (trial),
        .y      ({1'b0, b_reg}),
        .diff   (diff),
        .borrow (borrow)
    );

    // The remainder never exceeds the divisor, so its top bit only carries
    // the restoring headroom and is not reported
    assign rem_msb_unused = rem[2];

    // State and datapath registers; reset aborts any division in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            rem    <= '0;
            quot   <= '0;
            cnt    <= 1'b0;
            dz_reg <= 1'b0;
        end else begin
            state  <= state_next;
            a_reg  <= a_next;
            b_reg  <= b_next;
            rem    <= rem_next;
            quot   <= quot_next;
            cnt    <= cnt_next;
            dz_reg <= dz_next;
        end
    end

    // Next-state and datapath update: accept in IDLE/DONE, one restoring step per CALC edge
    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        rem_next   = rem;
        quot_next  = quot;
        cnt_next   = cnt;
        dz_next    = dz_reg;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_next  = a_in;
                    b_next  = b_in;
                    dz_next = 1'b0;
                    if (b_in != '0) begin
                        rem_next   = '0;
                        quot_next  = '0;
                        cnt_next   = 1'b1;
                        state_next = CALC;
                    end else begin
                        dz_next    = 1'b1;
                        quot_next  = DZ_QUOT;
                        rem_next   = DZ_REM_PASS ? {1'b0, a_in} : 3'b000;
                        cnt_next   = 1'b0;
                        state_next = DONE;
                    end
                end else if (state == DONE) begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (!borrow) begin
                    rem_next       = diff;
                    quot_next[cnt] = 1'b1;
                end else begin
                    rem_next       = trial;
                    quot_next[cnt] = 1'b0;
                end
                if (cnt == 1'b0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);
    assign dz   = dz_reg;
    assign q1   = quot[1];
    assign q0   = quot[0];
    assign r1   = rem[1];
    assign r0   = rem[0];

endmodule

// File: tb/tb_seq_divider_2bit.sv
// Directed self-checking bench for seq_divider_2bit. A second instance with
// the divide-by-zero remainder forced to zero shares the same stimulus.
module tb_seq_divider_2bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] a_in;
    logic [1:0] b_in;

    logic busy, done, dz, q0, q1, r0, r1;
    logic busy_z, done_z, dz_z, q0_z, q1_z, r0_z, r1_z;

    int compared   = 0;
    int mismatched = 0;

    seq_divider_2bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a0    (a_in[0]),
        .a1    (a_in[1]),
        .b0    (b_in[0]),
        .b1    (b_in[1]),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .q0    (q0),
        .q1    (q1),
        .r0    (r0),
        .r1    (r1)
    );

    seq_divider_2bit #(.DZ_QUOT(2'b11), .DZ_REM_PASS(1'b0)) dut_zero_rem (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a0    (a_in[0]),
        .a1    (a_in[1]),
        .b0    (b_in[0]),
        .b1    (b_in[1]),
        .busy  (busy_z),
        .done  (done_z),
        .dz    (dz_z),
        .q0    (q0_z),
        .q1    (q1_z),
        .r0    (r0_z),
        .r1    (r1_z)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Hard stop in case the stimulus itself gets stuck
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present operands with a one-cycle start; returns at the negedge after the accepting edge
    task automatic applyStimulus(input logic [1:0] a_val, input logic [1:0] b_val);
        @(negedge clk);
        a_in  = a_val;
        b_in  = b_val;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runDivision(input logic [1:0] a_val, input logic [1:0] b_val,
                               input logic [1:0] exp_q, input logic [1:0] exp_r,
                               input logic exp_dz, input string tag);
        int cycles;
        int exp_lat;
        exp_lat = exp_dz ? 1 : 3;
        applyStimulus(a_val, b_val);
        checkOutput({tag, "_busy"}, 8'(busy), 8'(!exp_dz));
        cycles = 1;
        while (!done && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, 8'(cycles), 8'(exp_lat));
        checkOutput({tag, "_q"}, 8'({q1, q0}), 8'(exp_q));
        checkOutput({tag, "_r"}, 8'({r1, r0}), 8'(exp_r));
        checkOutput({tag, "_dz"}, 8'(dz), 8'(exp_dz));
        if (exp_dz) begin
            checkOutput({tag, "_zr_done"}, 8'(done_z), 8'd1);
            checkOutput({tag, "_zr_q"}, 8'({q1_z, q0_z}), 8'h3);
            checkOutput({tag, "_zr_r"}, 8'({r1_z, r0_z}), 8'h0);
        end
        @(negedge clk);
        checkOutput({tag, "_pulse_end"}, 8'(done), 8'd0);
        checkOutput({tag, "_hold"}, 8'({dz, q1, q0, r1, r0}), 8'({exp_dz, exp_q, exp_r}));
    endtask

    initial begin
        int cycles;
        int dones;
        logic [1:0] eq, er;
        logic       edz;

        rst_n = 1'b0;
        start = 1'b1;
        a_in  = 2'b11;
        b_in  = 2'b01;

        // Reset held for two edges with start asserted must leave everything cleared
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", 8'({busy, done, dz, q1, q0, r1, r0}), 8'h00);
        checkOutput("reset_outputs_zr", 8'({busy_z, done_z, dz_z, q1_z, q0_z, r1_z, r0_z}), 8'h00);
        start = 1'b0;
        rst_n = 1'b1;

        $display("[TB] directed divisions");
        runDivision(2'b11, 2'b10, 2'b01, 2'b01, 1'b0, "div_3_2");
        runDivision(2'b11, 2'b01, 2'b11, 2'b00, 1'b0, "div_3_1");
        runDivision(2'b10, 2'b11, 2'b00, 2'b10, 1'b0, "div_2_3");
        runDivision(2'b01, 2'b00, 2'b11, 2'b01, 1'b1, "div_1_0");

        $display("[TB] back-to-back with start held");
        @(negedge clk);
        a_in  = 2'b11;
        b_in  = 2'b10;
        start = 1'b1;
        @(negedge clk);
        a_in  = 2'b10;
        b_in  = 2'b01;
        cycles = 1;
        while (!done && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("b2b_first_latency", 8'(cycles), 8'd3);
        checkOutput("b2b_first_qr", 8'({q1, q0, r1, r0}), 8'b0101);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 8);
        start = 1'b0;
        checkOutput("b2b_spacing", 8'(cycles), 8'd3);
        checkOutput("b2b_second_qr", 8'({q1, q0, r1, r0}), 8'b1000);
        checkOutput("b2b_second_dz", 8'(dz), 8'd0);
        @(negedge clk);
        checkOutput("b2b_idle_after", 8'(done), 8'd0);

        $display("[TB] start while busy is ignored");
        applyStimulus(2'b11, 2'b01);
        a_in  = 2'b10;
        b_in  = 2'b11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 2;
        while (!done && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("busy_start_latency", 8'(cycles), 8'd3);
        checkOutput("busy_start_qr", 8'({q1, q0, r1, r0}), 8'b1100);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("busy_start_single_done", 8'(dones), 8'd0);

        $display("[TB] reset during calculation");
        applyStimulus(2'b11, 2'b10);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_outputs", 8'({busy, done, dz, q1, q0, r1, r0}), 8'h00);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("midreset_no_done", 8'(dones), 8'd0);
        runDivision(2'b11, 2'b10, 2'b01, 2'b01, 1'b0, "after_reset");

        $display("[TB] exhaustive sweep");
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                if (bi == 0) begin
                    eq  = 2'b11;
                    er  = 2'(ai);
                    edz = 1'b1;
                end else begin
                    eq  = 2'(ai / bi);
                    er  = 2'(ai % bi);
                    edz = 1'b0;
                end
                runDivision(2'(ai), 2'(bi), eq, er, edz, $sformatf("sweep_a%0d_b%0d", ai, bi));
                if (bi != 0) begin
                    checkOutput($sformatf("sweep_inv_a%0d_b%0d", ai, bi),
                                8'(int'({q1, q0}) * bi + int'({r1, r0})), 8'(ai));
                    checkOutput($sformatf("sweep_rlt_a%0d_b%0d", ai, bi),
                                8'(int'({r1, r0}) < bi), 8'd1);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
